link_receiver: RTL and testbench

//  Synthesizable receiving end of the router's credit-based output channel; the consumer counterpart of the

---
 rtl/link_receiver.sv | 75 +++++++
 tb/tb_link_receiver.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/link_receiver.sv
// link_receiver: credit-based channel receiver with FIFO, framing check and packet counter
module link_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            diff_pair_in,
  input  logic [DATA_WIDTH-1:0] channel_in,
  output logic                  credit_out,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  err_line,
  output logic                  err_overflow,
  output logic                  err_frame,
  input  logic                  err_clear
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state, next_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] ty;
  logic pop, push_req, accept, line_err, frame_err, pkt_inc;
  assign flit_valid = count != '0;
  assign flit_out   = flit_valid ? mem[rd_ptr] : '0;
  assign pop        = flit_valid & flit_ready;
  assign push_req   = diff_pair_in == 2'b10;
  assign line_err   = diff_pair_in[1] == diff_pair_in[0];
  assign accept     = push_req & ((count != (AW+1)'(DEPTH)) | pop);
  assign ty         = channel_in[DATA_WIDTH-1 -: 2];
  // framing decode: type bit 0 marks a packet start, bit 1 marks a packet end
  always_comb begin
    next_state = state;
    frame_err  = 1'b0;
    pkt_inc    = 1'b0;
    if (accept) begin
      frame_err  = (state == IDLE) ? ~ty[0] : ty[0];
      pkt_inc    = (state == IDLE) ? (ty == 2'b11) : ty[1];
      next_state = (state == IDLE) ? ((ty == 2'b01) ? PKT : IDLE) : (ty[1] ? IDLE : PKT);
    end
  end
  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= channel_in;
  end
  // pointers, occupancy, credit return, packet count, sticky errors and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      credit_out   <= 1'b0;
      pkt_count    <= '0;
      err_line     <= 1'b0;
      err_overflow <= 1'b0;
      err_frame    <= 1'b0;
    end else begin
      state        <= next_state;
      wr_ptr       <= accept ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr       <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count        <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
      credit_out   <= pop;
      pkt_count    <= pkt_count + CNT_WIDTH'(pkt_inc);
      err_line     <= (err_line & ~err_clear) | line_err;
      err_overflow <= (err_overflow & ~err_clear) | (push_req & ~accept);
      err_frame    <= (err_frame & ~err_clear) | frame_err;
    end
  end
endmodule

// File: tb/tb_link_receiver.sv
// tb_link_receiver: table-driven directed checks of link_receiver
module tb_link_receiver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  diff_pair_in = 2'b01;
  logic [31:0] channel_in = '0;
  logic        credit_out, flit_valid, flit_ready = 1'b0;
  logic [31:0] flit_out;
  logic [15:0] pkt_count;
  logic        err_line, err_overflow, err_frame, err_clear = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [1:0]  diff;
    logic [31:0] data;
    logic        ready;
    logic        clr;
    logic        ev;
    logic [31:0] ef;
    logic        ec;
    logic [15:0] ep;
    logic [2:0]  ee;
  } vec_t;
  vec_t vq[$];

  link_receiver #(.DATA_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .diff_pair_in(diff_pair_in), .channel_in(channel_in),
    .credit_out(credit_out), .flit_out(flit_out), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .pkt_count(pkt_count), .err_line(err_line),
    .err_overflow(err_overflow), .err_frame(err_frame), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] d, input logic [31:0] x, input logic r, input logic c,
                     input logic ev, input logic [31:0] ef, input logic ec, input logic [15:0] ep,
                     input logic [2:0] ee);
    vec_t v;
    v = '{d, x, r, c, ev, ef, ec, ep, ee};
    vq.push_back(v);
  endtask

  task automatic check_all(input int idx, input logic ev, input logic [31:0] ef, input logic ec,
                           input logic [15:0] ep, input logic [2:0] ee);
    check("flit_valid", idx, 32'(flit_valid), 32'(ev));
    check("flit_out", idx, flit_out, ef);
    check("credit_out", idx, 32'(credit_out), 32'(ec));
    check("pkt_count", idx, 32'(pkt_count), 32'(ep));
    check("err_flags", idx, 32'({err_line, err_overflow, err_frame}), 32'(ee));
  endtask

  initial begin
    // single flit, popped immediately
    add(2'b10, 32'hC00000AA, 1, 0, 1, 32'hC00000AA, 0, 1, 3'b000);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 1, 1, 3'b000);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 0, 1, 3'b000);
    // four-flit packet held, then drained
    add(2'b10, 32'h40000001, 0, 0, 1, 32'h40000001, 0, 1, 3'b000);
    add(2'b10, 32'h00000002, 0, 0, 1, 32'h40000001, 0, 1, 3'b000);
    add(2'b10, 32'h00000003, 0, 0, 1, 32'h40000001, 0, 1, 3'b000);
    add(2'b10, 32'h80000004, 0, 0, 1, 32'h40000001, 0, 2, 3'b000);
    add(2'b01, 32'h0, 1, 0, 1, 32'h00000002, 1, 2, 3'b000);
    add(2'b01, 32'h0, 1, 0, 1, 32'h00000003, 1, 2, 3'b000);
    add(2'b01, 32'h0, 1, 0, 1, 32'h80000004, 1, 2, 3'b000);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 1, 2, 3'b000);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 0, 2, 3'b000);
    // overflow: fifth flit dropped without framing effect
    add(2'b10, 32'h40000011, 0, 0, 1, 32'h40000011, 0, 2, 3'b000);
    add(2'b10, 32'h00000012, 0, 0, 1, 32'h40000011, 0, 2, 3'b000);
    add(2'b10, 32'h00000013, 0, 0, 1, 32'h40000011, 0, 2, 3'b000);
    add(2'b10, 32'h80000014, 0, 0, 1, 32'h40000011, 0, 3, 3'b000);
    add(2'b10, 32'hC0000015, 0, 0, 1, 32'h40000011, 0, 3, 3'b010);
    add(2'b01, 32'h0, 1, 0, 1, 32'h00000012, 1, 3, 3'b010);
    add(2'b01, 32'h0, 1, 0, 1, 32'h00000013, 1, 3, 3'b010);
    add(2'b01, 32'h0, 1, 0, 1, 32'h80000014, 1, 3, 3'b010);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 1, 3, 3'b010);
    add(2'b01, 32'h0, 1, 1, 0, 32'h0, 0, 3, 3'b000);
    // full FIFO with simultaneous pop accepts the push
    add(2'b10, 32'hC0000021, 0, 0, 1, 32'hC0000021, 0, 4, 3'b000);
    add(2'b10, 32'hC0000022, 0, 0, 1, 32'hC0000021, 0, 5, 3'b000);
    add(2'b10, 32'hC0000023, 0, 0, 1, 32'hC0000021, 0, 6, 3'b000);
    add(2'b10, 32'hC0000024, 0, 0, 1, 32'hC0000021, 0, 7, 3'b000);
    add(2'b10, 32'hC0000025, 1, 0, 1, 32'hC0000022, 1, 8, 3'b000);
    add(2'b01, 32'h0, 1, 0, 1, 32'hC0000023, 1, 8, 3'b000);
    add(2'b01, 32'h0, 1, 0, 1, 32'hC0000024, 1, 8, 3'b000);
    add(2'b01, 32'h0, 1, 0, 1, 32'hC0000025, 1, 8, 3'b000);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 1, 8, 3'b000);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 0, 8, 3'b000);
    // line errors, clear, and new error winning over clear
    add(2'b11, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0, 8, 3'b100);
    add(2'b01, 32'h0, 1, 1, 0, 32'h0, 0, 8, 3'b000);
    add(2'b00, 32'h0, 1, 1, 0, 32'h0, 0, 8, 3'b100);
    add(2'b01, 32'h0, 1, 1, 0, 32'h0, 0, 8, 3'b000);
    // framing: body in IDLE, head in PKT, single in PKT, tail in IDLE
    add(2'b10, 32'h00000001, 0, 0, 1, 32'h00000001, 0, 8, 3'b001);
    add(2'b10, 32'h40000002, 0, 1, 1, 32'h00000001, 0, 8, 3'b000);
    add(2'b10, 32'h40000003, 0, 0, 1, 32'h00000001, 0, 8, 3'b001);
    add(2'b10, 32'hC0000004, 0, 0, 1, 32'h00000001, 0, 9, 3'b001);
    add(2'b10, 32'h80000005, 0, 0, 1, 32'h00000001, 0, 9, 3'b011);
    add(2'b01, 32'h0, 1, 0, 1, 32'h40000002, 1, 9, 3'b011);
    add(2'b01, 32'h0, 1, 0, 1, 32'h40000003, 1, 9, 3'b011);
    add(2'b01, 32'h0, 1, 0, 1, 32'hC0000004, 1, 9, 3'b011);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 1, 9, 3'b011);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 0, 9, 3'b011);
    add(2'b10, 32'h80000006, 1, 1, 1, 32'h80000006, 0, 9, 3'b001);
    add(2'b01, 32'h0, 1, 0, 0, 32'h0, 1, 9, 3'b001);

    #12 check_all(-1, 0, 32'h0, 0, 16'h0, 3'b000);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      check("idle_credit", i, 32'(credit_out), 32'h0);
    end
    foreach (vq[i]) begin
      diff_pair_in = vq[i].diff;
      channel_in   = vq[i].data;
      flit_ready   = vq[i].ready;
      err_clear    = vq[i].clr;
      @(posedge clk) #1;
      check_all(i, vq[i].ev, vq[i].ef, vq[i].ec, vq[i].ep, vq[i].ee);
    end
    // reset mid-operation with flits buffered
    flit_ready = 1'b0;
    err_clear = 1'b0;
    diff_pair_in = 2'b10;
    channel_in = 32'h40000031;
    @(posedge clk) #1;
    channel_in = 32'h00000032;
    @(posedge clk) #1;
    diff_pair_in = 2'b01;
    check("pre_reset_valid", 100, 32'(flit_valid), 32'h1);
    #2 rst = 1'b1;
    #1 check_all(100, 0, 32'h0, 0, 16'h0, 3'b000);
    flit_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      check("post_reset_credit", i, 32'(credit_out), 32'h0);
      check("post_reset_valid", i, 32'(flit_valid), 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
